pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the 5-stage RISC-V pipeline. It sits beside the EX-stage forwarding logic and drives the per-stage pipeline-register enables and flushes. It handles three cases: load-use hazards that forwarding cannot cover, taken-branch flushes, and multi-cycle data-memory waits. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_ctrl_pkg.sv | 30 +++
 rtl/sat_counter.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types and constants used by the hazard controller,
// the forwarding unit and the pipeline-register blocks.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Control-bundle field widths carried through ID/EX, EX/MEM and MEM/WB
    localparam int ALU_OP_W  = 4;
    localparam int EX_CTRL_W = ALU_OP_W + 2;
    localparam int MEM_CTRL_W = 3;
    localparam int WB_CTRL_W = 2;

    // True when the ID instruction needs the load result before it can be forwarded
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return mem_read && (rd != REG_X0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: memory-wait freeze, branch flush and load-use
// stall for the 5-stage pipeline, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             mem_read__id_ex,
    input  logic [4:0]       rd__id_ex,
    input  logic [4:0]       rs1__if_id,
    input  logic [4:0]       rs2__if_id,
    input  logic             uses_rs2__if_id,
    input  logic             branch_taken__ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             en_pc,
    output logic             en_if_id,
    output logic             en_id_ex,
    output logic             en_ex_mem,
    output logic             en_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_e state_q, state_d;
    logic        pend_flush_q, pend_flush_d;
    logic        freeze, do_flush, load_use;

    assign freeze   = dmem_req && !dmem_ready;
    assign do_flush = branch_taken__ex || pend_flush_q;
    assign load_use = load_use_hit(mem_read__id_ex, rd__id_ex, rs1__if_id,
                                   rs2__if_id, uses_rs2__if_id);

    always_comb begin
        en_pc       = 1'b1;
        en_if_id    = 1'b1;
        en_id_ex    = 1'b1;
        en_ex_mem   = 1'b1;
        en_mem_wb   = 1'b1;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (freeze) begin
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (do_flush) begin
            // The ID instruction is discarded, so a load-use match is moot
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            en_pc       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (freeze) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // A branch pulse seen while frozen is held until the first unfrozen cycle
    assign pend_flush_d = freeze && (pend_flush_q || branch_taken__ex);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= RUN;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (!en_pc),
        .count  (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (flush_if_id),
        .count  (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan scenarios
// followed by randomized traffic against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             mem_read__id_ex = 1'b0;
    logic [4:0]       rd__id_ex = '0;
    logic [4:0]       rs1__if_id = '0;
    logic [4:0]       rs2__if_id = '0;
    logic             uses_rs2__if_id = 1'b0;
    logic             branch_taken__ex = 1'b0;
    logic             dmem_req = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic             flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] stall_count, flush_count;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .mem_read__id_ex  (mem_read__id_ex),
        .rd__id_ex        (rd__id_ex),
        .rs1__if_id       (rs1__if_id),
        .rs2__if_id       (rs2__if_id),
        .uses_rs2__if_id  (uses_rs2__if_id),
        .branch_taken__ex (branch_taken__ex),
        .dmem_req         (dmem_req),
        .dmem_ready       (dmem_ready),
        .en_pc            (en_pc),
        .en_if_id         (en_if_id),
        .en_id_ex         (en_id_ex),
        .en_ex_mem        (en_ex_mem),
        .en_mem_wb        (en_mem_wb),
        .flush_if_id      (flush_if_id),
        .flush_id_ex      (flush_id_ex),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    tag;
        bit [6:0] ctrl;   // {en_pc,en_if_id,en_id_ex,en_ex_mem,en_mem_wb,flush_if_id,flush_id_ex}
        int       stalls;
        int       flushes;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain integers and a pending-branch flag
    int m_stalls  = 0;
    int m_flushes = 0;
    bit m_pend    = 0;

    // Monitor: every cycle the DUT presents outputs; compare against the queue
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            bit [6:0] act;
            e   = q.pop_front();
            act = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl: got %b want %b", e.tag, act, e.ctrl);
            end
            checks++;
            if (int'(stall_count) != e.stalls) begin
                errors++;
                $display("FAIL %s stall_count: got %0d want %0d", e.tag, stall_count, e.stalls);
            end
            checks++;
            if (int'(flush_count) != e.flushes) begin
                errors++;
                $display("FAIL %s flush_count: got %0d want %0d", e.tag, flush_count, e.flushes);
            end
        end
    end

    // One clock cycle: drive inputs, push the expectation, advance the model at the edge
    task automatic cyc(input string tag, input bit rst, input bit mr, input int rd,
                       input int rs1, input int rs2, input bit u2, input bit br,
                       input bit req, input bit rdy);
        exp_t e;
        bit   freeze, flush, lu;
        arst_n           = ~rst;
        mem_read__id_ex  = mr;
        rd__id_ex        = 5'(rd);
        rs1__if_id       = 5'(rs1);
        rs2__if_id       = 5'(rs2);
        uses_rs2__if_id  = u2;
        branch_taken__ex = br;
        dmem_req         = req;
        dmem_ready       = rdy;
        if (rst) begin
            m_stalls = 0; m_flushes = 0; m_pend = 0;
        end
        freeze = req && !rdy;
        flush  = !freeze && (br || m_pend);
        lu     = mr && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
        if (freeze)     e.ctrl = 7'b00000_00;
        else if (flush) e.ctrl = 7'b11111_11;
        else if (lu)    e.ctrl = 7'b00111_01;
        else            e.ctrl = 7'b11111_00;
        e.tag = tag; e.stalls = m_stalls; e.flushes = m_flushes;
        q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            if (!e.ctrl[6]) m_stalls  = (m_stalls  + 1 > CMAX) ? CMAX : m_stalls + 1;
            if (e.ctrl[1])  m_flushes = (m_flushes + 1 > CMAX) ? CMAX : m_flushes + 1;
            m_pend = freeze && (m_pend || br);
        end
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset("reset");
        idle("reset_idle");

        cyc("lu_rs1", 0, 1, 5, 5, 0, 0, 0, 0, 0);
        idle("lu_rs1_after");

        do_reset("rst1");
        cyc("nostall_x0", 0, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc("nostall_rs2", 0, 1, 7, 3, 7, 0, 0, 0, 0);
        cyc("lu_rs2", 0, 1, 7, 3, 7, 1, 0, 0, 0);
        idle("nostall_after");

        do_reset("rst2");
        cyc("br_vs_lu", 0, 1, 5, 5, 0, 0, 1, 0, 0);
        idle("br_vs_lu_after");

        do_reset("rst3");
        cyc("memw1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("memw2_br", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc("memw3", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("memw_ready", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("memw_after");
        idle("memw_after2");

        do_reset("rst4");
        for (int i = 0; i < 20; i++) cyc("sat_freeze", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("sat_after");

        do_reset("rst5");
        cyc("rstf_br", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc("rstf_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("rstf_assert", 1, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("rstf_ready", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("rstf_after");

        for (int i = 0; i < 2000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 199) == 0);
            cyc("rand", rst, 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
        end
        idle("final");

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
